pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised inter-stage pipeline register that generalises the fixed EX/MEM latch into a reusable valid/ready stage with stall back-pressure, synchronous flush, and an optional two-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the CPU and carries a control field and a data field. The control field is cleared on flush. The data field is held on flush.

## Interface
Parameters:
- CTRL_W, 16, width of control field (branch/j/regWr/memWr/… bundle); zeroed on reset and flush
- DATA_W, 128, width of data field (aluResult, busA, busB, imm, rw, PC …); zeroed on reset only
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, in_ready combinational

Ports:
- clk  in  1  clock; all state updates on posedge
- regReset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held entries (control hazard / exception)
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  stage can accept; handshake = in_valid & in_ready
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts; handshake = out_valid & out_ready
- out_ctrl  out  CTRL_W  control to next stage; all-zero whenever out_valid=0
- out_data  out  DATA_W  data to next stage; don't-care when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Entries: main slot (drives outputs) and, if SKID=1, skid slot. FIFO order always preserved.
- SKID=1 state machine over {EMPTY, ONE, TWO}:
  - EMPTY: accept → ONE (load main).
  - ONE: accept & !pop → TWO (load skid); pop & !accept → EMPTY; accept & pop → ONE (load main from input).
  - TWO: pop → ONE (skid moves into main); no accept possible.
- SKID=1: in_ready = (state != TWO), a registered signal (no combinational path from out_ready).
- SKID=0: in_ready = !out_valid | out_ready. The main slot loads on accept and clears valid on pop without accept.
- flush: next cycle is EMPTY, out_valid=0, and both control slots are zero. Any input handshaking in the flush cycle is discarded. Data registers keep their values.
- regReset has priority over flush. flush has priority over handshakes.
- An invalid slot always holds control = 0. A stale valid control bit can never reach the next stage.

## Timing
- Reset: out_valid=0, in_ready=1 (the cycle after reset is released), out_ctrl=0, out_data=0, occupancy=0, state=EMPTY.
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle).
- Throughput: one entry per cycle with out_ready held high, in both modes.
- SKID=1 stall: out_ready drops while in ONE. One more entry is accepted (→ TWO), then in_ready=0 from the next cycle.
- When out_ready returns, the main entry pops first, then the skid entry on the following cycle. in_ready returns one cycle after the first pop.
- Reset asserted mid-stream: all entries are lost. There is no partial state.
- Simultaneous flush and pop: the pop counts downstream. The stage is empty afterwards.

## Structure
- Shared package pipe_pkg: state enum {EMPTY=2'd0, ONE=2'd1, TWO=2'd2}, and the default CTRL_W/DATA_W constants used by each pipeline stage instance.
- Sub-module pipe_slot (valid + ctrl + data register with load / clear-ctrl / reset controls), instantiated once for main and once for skid when SKID=1 (generate).

## Test plan
- Reset: hold regReset 2 cycles with in_valid=1, in_ctrl=16'hFFFF → out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in_ready=1 on the first cycle after release.
- Streaming (SKID=1): 8 back-to-back entries, data=1..8, out_ready=1 → outputs 1..8 on consecutive cycles, each one cycle after accept, in_ready never low.
- Stall and skid (SKID=1):
  - Send data 0xA, 0xB, 0xC with out_ready=0 from the second cycle → 0xA and 0xB accepted, occupancy=2, in_ready=0, 0xC held upstream.
  - Raise out_ready → output order 0xA, 0xB, 0xC with no loss or duplication.
- Flush: occupancy=2, ctrl=16'h00FF in both slots; pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, input entry discarded, out_data unchanged.
- Priority: assert regReset and flush together while full → reset values, including out_data=0.
- SKID=0 variant: random in_valid/out_ready for 1000 cycles against a scoreboard → in-order, lossless delivery; in_ready equals !out_valid | out_ready every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage buffer used between CPU stages.
// Holds the occupancy state encoding and the default field widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_DATA_W = 128;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid flag, control field and data field.
// Invalidation zeroes control but keeps data; reset zeroes everything.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              regReset,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data_reg;

    // Clear wins over load so a flushed entry can never leave a stale control bit behind.
    always_ff @(posedge clk) begin
        if (regReset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            data_reg  <= '0;
        end else if (clr) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            ctrl_reg  <= in_ctrl;
            data_reg  <= in_data;
        end
    end

    assign valid = valid_reg;
    assign ctrl  = ctrl_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Reusable inter-stage pipeline register with valid/ready handshake, flush and
// an optional two-entry skid buffer that makes in_ready a pure register output.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              regReset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic              pop;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    assign accept = in_valid & in_ready;
    assign pop    = main_valid & out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk      (clk),
        .regReset (regReset),
        .load     (main_load),
        .clr      (main_clr),
        .in_ctrl  (main_ctrl_in),
        .in_data  (main_data_in),
        .valid    (main_valid),
        .ctrl     (main_ctrl),
        .data     (main_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            state_t            state_reg;
            state_t            state_next;
            logic              skid_load;
            logic              skid_clr;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk      (clk),
                .regReset (regReset),
                .load     (skid_load),
                .clr      (skid_clr),
                .in_ctrl  (in_ctrl),
                .in_data  (in_data),
                .valid    (skid_valid),
                .ctrl     (skid_ctrl),
                .data     (skid_data)
            );

            // When full, the main slot refills from the skid slot to keep FIFO order.
            assign main_ctrl_in = (state_reg == TWO) ? skid_ctrl : in_ctrl;
            assign main_data_in = (state_reg == TWO) ? skid_data : in_data;
            assign in_ready     = (state_reg != TWO);
            assign occupancy    = {skid_valid, main_valid & ~skid_valid};

            always_comb begin
                state_next = state_reg;
                main_load  = 1'b0;
                main_clr   = 1'b0;
                skid_load  = 1'b0;
                skid_clr   = 1'b0;
                if (flush) begin
                    state_next = EMPTY;
                    main_clr   = 1'b1;
                    skid_clr   = 1'b1;
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (accept) begin
                                main_load  = 1'b1;
                                state_next = ONE;
                            end
                        end
                        ONE: begin
                            if (accept && !pop) begin
                                skid_load  = 1'b1;
                                state_next = TWO;
                            end else if (pop && !accept) begin
                                main_clr   = 1'b1;
                                state_next = EMPTY;
                            end else if (accept && pop) begin
                                main_load  = 1'b1;
                            end
                        end
                        TWO: begin
                            if (pop) begin
                                main_load  = 1'b1;
                                skid_clr   = 1'b1;
                                state_next = ONE;
                            end
                        end
                        default: state_next = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (regReset) begin
                    state_reg <= EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end
        end else begin : g_single
            assign main_ctrl_in = in_ctrl;
            assign main_data_in = in_data;
            assign in_ready     = !main_valid || out_ready;
            assign occupancy    = {1'b0, main_valid};

            always_comb begin
                main_load = 1'b0;
                main_clr  = 1'b0;
                if (flush) begin
                    main_clr = 1'b1;
                end else if (accept) begin
                    main_load = 1'b1;
                end else if (pop) begin
                    main_clr = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a skid (SKID=1) and a single-entry (SKID=0) stage with shared stimulus and
// compares both against queue models of a bounded in-order buffer.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW = 16;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          regReset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
        .clk(clk), .regReset(regReset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .regReset(regReset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q1[$];
    ent_t          q0[$];
    int            checks   = 0;
    int            failures = 0;
    logic          acc1, acc0, pop1, pop0;
    logic [DW-1:0] saved_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Skid stage holds up to two entries and its in_ready reflects the count at cycle start;
    // the single stage holds one and is ready when empty or draining.
    task automatic check_outputs(input string tag);
        chk({tag, ".ov1"}, out_valid1, q1.size() != 0);
        chk({tag, ".oc1"}, out_ctrl1, (q1.size() != 0) ? q1[0].c : '0);
        chk({tag, ".ir1"}, in_ready1, q1.size() < 2);
        chk({tag, ".occ1"}, occ1, q1.size());
        if (q1.size() != 0) chk({tag, ".od1"}, out_data1, q1[0].d);
        chk({tag, ".ov0"}, out_valid0, q0.size() != 0);
        chk({tag, ".oc0"}, out_ctrl0, (q0.size() != 0) ? q0[0].c : '0);
        chk({tag, ".ir0"}, in_ready0, (q0.size() == 0) || out_ready);
        chk({tag, ".occ0"}, occ0, q0.size());
        if (q0.size() != 0) chk({tag, ".od0"}, out_data0, q0[0].d);
    endtask

    task automatic step(input string tag);
        #1;
        check_outputs(tag);
        acc1 = in_valid && (q1.size() < 2);
        pop1 = (q1.size() != 0) && out_ready;
        acc0 = in_valid && ((q0.size() == 0) || out_ready);
        pop0 = (q0.size() != 0) && out_ready;
        if (pop1 && !regReset)
            $display("xfer %s skid1 ctrl=%h data=%0h", tag, q1[0].c, q1[0].d);
        @(posedge clk);
        if (regReset || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1) void'(q1.pop_front());
            if (acc1) q1.push_back(ent_t'{in_ctrl, in_data});
            if (pop0) void'(q0.pop_front());
            if (acc0) q0.push_back(ent_t'{in_ctrl, in_data});
        end
        #1;
    endtask

    initial begin
        regReset  = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'hFFFF;
        in_data   = '1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        step("rst");
        chk("rst.od1", out_data1, '0);
        chk("rst.od0", out_data0, '0);
        regReset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst.ir1_release", in_ready1, 1'b1);

        // Back-to-back streaming with downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i * 3);
            in_data  = DW'(i);
            step("stream");
            chk("stream.ir1_high", in_ready1, 1'b1);
        end
        in_valid = 1'b0;
        step("stream_drain");
        step("stream_drain");

        // Stall into the skid slot, then release.
        in_valid = 1'b1; in_ctrl = 16'h000A; in_data = DW'(32'hA); out_ready = 1'b1;
        step("stall");
        in_ctrl = 16'h000B; in_data = DW'(32'hB); out_ready = 1'b0;
        step("stall");
        in_ctrl = 16'h000C; in_data = DW'(32'hC);
        step("stall");
        chk("stall.occ1_full", occ1, 2'd2);
        chk("stall.ir1_low", in_ready1, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step("release");
            if (acc1) break;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step("release_drain");

        // Fill both slots with ctrl 00FF, then flush with a live input.
        in_valid = 1'b1; in_ctrl = 16'h00FF; out_ready = 1'b0;
        in_data = DW'(32'h111); step("fill");
        in_data = DW'(32'h222); step("fill");
        chk("fill.occ1", occ1, 2'd2);
        saved_data = q1[0].d;
        flush = 1'b1; in_data = DW'(32'h333);
        step("flush");
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush.od1_held", out_data1, saved_data);
        chk("flush.oc1_zero", out_ctrl1, '0);
        step("post_flush");

        // Reset and flush together while full.
        in_valid = 1'b1; in_ctrl = 16'h00FF; out_ready = 1'b0;
        in_data = DW'(32'h444); step("fill2");
        in_data = DW'(32'h555); step("fill2");
        regReset = 1'b1; flush = 1'b1;
        step("rst_flush");
        regReset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("prio.od1_zero", out_data1, '0);
        chk("prio.od0_zero", out_data0, '0);
        step("post_prio");

        // Random traffic with occasional flushes.
        for (int n = 0; n < 1000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            step("rand");
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
